// File: rtl/ffsr_spike_scheduler.sv
// ffsr_spike_scheduler
//
// Shares the single update port of an FFSR spike-counter bank between
// N_REQ spike requesters. Each granted request becomes one inc or dec strobe
// to the counter whose index matches the requester. Requests are arbitrated
// round-robin with a valid/ready handshake.
//
// A free-running leak timer periodically asks for a leak sweep. A sweep
// issues one decrement to every counter index in turn. Request service then
// resumes. Leak has priority over requests.
//
// Parameters
//   N_REQ        number of requesters, which is also the number of counter indices (>=2)
//   IDX_W        width of upd_idx, clog2(N_REQ)
//   LEAK_PERIOD  cycles between leak triggers while leak_en=1 (>=2)
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst        in   synchronous active-high reset
//   req_valid  in   [N_REQ] per-requester spike request
//   req_dec    in   [N_REQ] per-requester direction, 1=dec 0=inc, stable while valid
//   req_ready  out  [N_REQ] one-hot combinational grant, zero outside IDLE
//   leak_en    in   enables the leak timer
//   upd_valid  out  registered update strobe to the counter bank
//   upd_idx    out  [IDX_W] target counter index
//   upd_inc    out  increment strobe
//   upd_dec    out  decrement strobe
//   leak_busy  out  high while a leak sweep is in progress
//   stall_cnt  out  [16] saturating count of stalled request cycles
//                   (present only when FFSR_SCHED_STATS_EN is defined)
//
// Configuration
//   FFSR_SCHED_STATS_EN  when defined, adds the stall_cnt port and its counter.

module ffsr_spike_scheduler #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 2,
  parameter int LEAK_PERIOD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_dec,
  output logic [N_REQ-1:0] req_ready,
  input  logic             leak_en,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_inc,
  output logic             upd_dec,
  output logic             leak_busy
`ifdef FFSR_SCHED_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int TIMER_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(LEAK_PERIOD - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LEAK = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   sweep_idx, sweep_idx_nxt;
  logic [TIMER_W-1:0] timer;
  logic               leak_pend;
  logic               pend_clr;

  logic               found;
  logic [IDX_W-1:0]   winner;

  logic               upd_valid_nxt;
  logic [IDX_W-1:0]   upd_idx_nxt;
  logic               upd_dir, upd_dir_nxt;

  // Round-robin search: the first valid requester at or after rr_ptr,
  // wrapping modulo N_REQ.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cidx;
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    cidx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cidx = IDX_W'(cand);
      if (!found && req_valid[cidx]) begin
        found  = 1'b1;
        winner = cidx;
      end
    end
  end

  // Next-state and grant logic. Grants are withheld during reset because the
  // requester would drop its request while the update it asked for is lost.
  // A pending leak blocks grants in IDLE so the sweep entry cycle issues
  // nothing.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    sweep_idx_nxt = sweep_idx;
    pend_clr      = 1'b0;
    req_ready     = '0;
    upd_valid_nxt = 1'b0;
    upd_idx_nxt   = upd_idx;
    upd_dir_nxt   = upd_dir;
    case (state)
      IDLE: begin
        if (leak_pend) begin
          state_nxt     = LEAK;
          sweep_idx_nxt = '0;
          pend_clr      = 1'b1;
        end else if (found && !rst) begin
          req_ready[winner] = 1'b1;
          upd_valid_nxt     = 1'b1;
          upd_idx_nxt       = winner;
          upd_dir_nxt       = req_dec[winner];
          rr_ptr_nxt        = (winner == LAST_IDX) ? '0 : winner + 1'b1;
        end
      end
      LEAK: begin
        upd_valid_nxt = 1'b1;
        upd_idx_nxt   = sweep_idx;
        upd_dir_nxt   = 1'b1;
        if (sweep_idx == LAST_IDX) begin
          state_nxt     = IDLE;
          sweep_idx_nxt = '0;
        end else begin
          sweep_idx_nxt = sweep_idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, arbitration pointer, sweep position, and the registered update port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sweep_idx <= '0;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_dir   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      sweep_idx <= sweep_idx_nxt;
      upd_valid <= upd_valid_nxt;
      upd_idx   <= upd_idx_nxt;
      upd_dir   <= upd_dir_nxt;
    end
  end

  // Leak timer. It keeps running during a sweep. A wrap that coincides with
  // the consumption of an older trigger wins, so a trigger is never lost.
  // A wrap that finds leak_pend already set merges into that trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      leak_pend <= 1'b0;
    end else if (!leak_en) begin
      timer     <= '0;
      leak_pend <= 1'b0;
    end else if (timer == TIMER_LAST) begin
      timer     <= '0;
      leak_pend <= 1'b1;
    end else begin
      timer <= timer + 1'b1;
      if (pend_clr) begin
        leak_pend <= 1'b0;
      end
    end
  end

  assign upd_inc   = upd_valid & ~upd_dir;
  assign upd_dec   = upd_valid & upd_dir;
  assign leak_busy = (state == LEAK);

`ifdef FFSR_SCHED_STATS_EN
  logic stall;

  assign stall = (|req_valid) & ~(|(req_valid & req_ready));

  // Counts cycles in which someone is asking but nobody transfers.
  // The count saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ffsr_spike_scheduler.sv
// Testbench for ffsr_spike_scheduler.
// Reference model: a cycle-level behavioural description kept in plain
// integers (sweep position, pointer, timer) plus a one-deep queue of the
// update that the bank is expected to see next cycle.

module tb_ffsr_spike_scheduler;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int LP    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] req_valid = '0;
  logic [N_REQ-1:0] req_dec = '0;
  logic [N_REQ-1:0] req_ready;
  logic             leak_en = 1'b0;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_inc;
  logic             upd_dec;
  logic             leak_busy;
`ifdef FFSR_SCHED_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  ffsr_spike_scheduler #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W),
    .LEAK_PERIOD(LP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_dec(req_dec),
    .req_ready(req_ready),
    .leak_en(leak_en),
    .upd_valid(upd_valid),
    .upd_idx(upd_idx),
    .upd_inc(upd_inc),
    .upd_dec(upd_dec),
    .leak_busy(leak_busy)
`ifdef FFSR_SCHED_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state.
  bit               m_known = 1'b0;
  int               m_rr    = 0;
  int               m_timer = 0;
  bit               m_pend  = 1'b0;
  bit               m_sweep = 1'b0;
  int               m_pos   = 0;
  bit               e_valid = 1'b0;
  int               e_idx   = 0;
  bit               e_dec   = 1'b0;
  logic [N_REQ-1:0] exp_ready;
  int               m_stall = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the DUT against the model, and then
  // advances the model by one clock.
  task automatic applyStimulus(input logic r, input logic le,
                               input logic [N_REQ-1:0] v, input logic [N_REQ-1:0] d);
    int g;
    bit consume;
    @(negedge clk);
    rst       = r;
    leak_en   = le;
    req_valid = v;
    req_dec   = d;
    #1;
    g         = -1;
    exp_ready = '0;
    if (!r && !m_sweep && !m_pend) begin
      for (int k = 0; k < N_REQ; k++) begin
        int c;
        c = (m_rr + k) % N_REQ;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    if (m_known) begin
      checkOutput("upd_valid", 32'(upd_valid), 32'(e_valid));
      checkOutput("upd_inc", 32'(upd_inc), 32'(e_valid & ~e_dec));
      checkOutput("upd_dec", 32'(upd_dec), 32'(e_valid & e_dec));
      if (e_valid) checkOutput("upd_idx", 32'(upd_idx), 32'(e_idx));
      checkOutput("leak_busy", 32'(leak_busy), 32'(m_sweep));
`ifdef FFSR_SCHED_STATS_EN
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    end
    if (r) begin
      m_rr = 0; m_timer = 0; m_pend = 0; m_sweep = 0; m_pos = 0;
      e_valid = 0; e_idx = 0; e_dec = 0; m_stall = 0; m_known = 1;
    end else begin
      if (m_known && (|v) && !(|(v & exp_ready)) && m_stall < 65535) m_stall++;
      consume = 0;
      e_valid = 0;
      if (m_sweep) begin
        e_valid = 1; e_idx = m_pos; e_dec = 1;
        m_pos++;
        if (m_pos == N_REQ) begin
          m_sweep = 0;
          m_pos   = 0;
        end
      end else if (m_pend) begin
        m_sweep = 1; m_pos = 0; consume = 1;
      end else if (g >= 0) begin
        e_valid = 1; e_idx = g; e_dec = d[g];
        m_rr = (g + 1) % N_REQ;
      end
      if (!le) begin
        m_timer = 0; m_pend = 0;
      end else if (m_timer == LP - 1) begin
        m_timer = 0; m_pend = 1;
      end else begin
        m_timer++;
        if (consume) m_pend = 0;
      end
    end
  endtask

  initial begin
    logic [N_REQ-1:0] cur_v;
    logic [N_REQ-1:0] cur_d;
    logic             le;
    logic             r;
    int               busy_cycles;
    bit               done;

    // Reset with every requester asking.
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000);
    checkOutput("reset_upd_idx", 32'(upd_idx), 32'd0);

    // Round-robin with all requesters incrementing.
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000);

    // Fairness/skip with requester 3 decrementing.
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 4'b1010, 4'b1000);

    // Idle leak sweep.
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    busy_cycles = 0;
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
      if (leak_busy === 1'b1) busy_cycles++;
    end
    checkOutput("leak_busy_cycles", 32'(busy_cycles), 32'd4);

    // Requester 2 arrives just as the leak trigger fires.
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < LP - 1; c++) applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      applyStimulus(1'b0, 1'b1, 4'b0100, 4'b0000);
      done = exp_ready[2];
    end
    checkOutput("grant2_after_sweep", 32'(done), 32'd1);

    // Reset in the middle of a sweep.
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
      done = m_sweep && (m_pos == 1);
    end
    checkOutput("reach_sweep_idx1", 32'(done), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
    checkOutput("midsweep_rst_valid", 32'(upd_valid), 32'd0);
    checkOutput("midsweep_rst_busy", 32'(leak_busy), 32'd0);
    for (int c = 0; c < 24; c++) applyStimulus(1'b0, 1'b1, 4'b0000, 4'b0000);

    // Randomized traffic. Requesters hold valid and direction until granted.
    cur_v = '0;
    cur_d = '0;
    le    = 1'b1;
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 59) == 0) le = ~le;
      applyStimulus(r, le, cur_v, cur_d);
      for (int i = 0; i < N_REQ; i++) begin
        if (exp_ready[i]) begin
          cur_v[i] = 1'($urandom_range(0, 1));
          cur_d[i] = 1'($urandom_range(0, 1));
        end else if (!cur_v[i] && $urandom_range(0, 2) == 0) begin
          cur_v[i] = 1'b1;
          cur_d[i] = 1'($urandom_range(0, 1));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
